// File: rtl/gamepkg.sv
// Shared game definitions: piece codes, ROM geometry and piece-ROM arbiter states.
// Used by the piece-ROM arbiter, the ROM model and the game controller.
package gamepkg;

  localparam int unsigned ROM_ADDR_W = 7;
  localparam int unsigned ROM_DATA_W = 8;
  localparam int unsigned PIECE_W    = 4;
  localparam int unsigned SHAPE_W    = 16;

  // Piece codes; 0 and anything above CURSED do not index the shape ROM
  localparam logic [PIECE_W-1:0] PIECE_NONE        = 4'd0;
  localparam logic [PIECE_W-1:0] PIECE_T           = 4'd1;
  localparam logic [PIECE_W-1:0] PIECE_J           = 4'd2;
  localparam logic [PIECE_W-1:0] PIECE_L           = 4'd3;
  localparam logic [PIECE_W-1:0] PIECE_O           = 4'd4;
  localparam logic [PIECE_W-1:0] PIECE_S           = 4'd5;
  localparam logic [PIECE_W-1:0] PIECE_Z           = 4'd6;
  localparam logic [PIECE_W-1:0] PIECE_I           = 4'd7;
  localparam logic [PIECE_W-1:0] PIECE_CURSED      = 4'd8;
  localparam logic [PIECE_W-1:0] PIECE_FLASH_COLOR = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IDX   = 3'd1,
    ST_PTR   = 3'd2,
    ST_ROW01 = 3'd3,
    ST_ROW23 = 3'd4,
    ST_RESP  = 3'd5
  } arb_state_t;

  // True for codes that have an entry in the shape ROM
  function automatic logic piece_valid(input logic [PIECE_W-1:0] code);
    return (code >= PIECE_T) && (code <= PIECE_CURSED);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
// Ports: i_req_valid - pending requests; i_rr_ptr - favoured requester on a tie;
//        o_grant_c   - one-hot grant (all zero when nothing is pending).
module rr_arbiter2 (
  input  logic [1:0] i_req_valid,
  input  logic       i_rr_ptr,
  output logic [1:0] o_grant_c
);

  // A lone requester always wins; the pointer only breaks ties
  always_comb begin
    o_grant_c = i_req_valid;
    if (&i_req_valid) begin
      o_grant_c = i_rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/piece_rom_arbiter.sv
// Shares the piece-shape ROM between the spawner and the preview.
// Performs code -> pointer byte -> two shape bytes and returns a 4x4 shape.
// Ports: clk/rst (sync, active-high); req_valid/req_piece/req_ready - requester
//        handshakes; resp_* - result handshake and payload; rom_addr/rom_data -
//        synchronous-read ROM (data one cycle after address).
module piece_rom_arbiter
  import gamepkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = ROM_ADDR_W,
  parameter int unsigned DATA_W  = ROM_DATA_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][PIECE_W-1:0] req_piece,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic                            resp_id,
  output logic [PIECE_W-1:0]              resp_piece,
  output logic [SHAPE_W-1:0]              resp_shape,
  output logic                            resp_err,
  output logic [ADDR_W-1:0]               rom_addr,
  input  logic [DATA_W-1:0]               rom_data
);

  arb_state_t         r_state, w_state_nxt;
  logic               r_rr_ptr, w_rr_ptr_nxt;
  logic               r_id, w_id_nxt;
  logic [PIECE_W-1:0] r_piece, w_piece_nxt;
  logic [ADDR_W-1:0]  r_ptr, w_ptr_nxt;
  logic [SHAPE_W-1:0] r_shape, w_shape_nxt;
  logic               r_err, w_err_nxt;
  logic               r_resp_valid;

  logic [1:0]         w_grant;
  logic               w_accept;
  logic               w_sel;

  rr_arbiter2 u_rr_arbiter2 (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant_c   (w_grant)
  );

  assign w_sel    = w_grant[1];
  assign w_accept = (r_state == ST_IDLE) && (|(req_valid & w_grant));

  // State and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= 1'b0;
      r_id         <= 1'b0;
      r_piece      <= '0;
      r_ptr        <= '0;
      r_shape      <= '0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_id         <= w_id_nxt;
      r_piece      <= w_piece_nxt;
      r_ptr        <= w_ptr_nxt;
      r_shape      <= w_shape_nxt;
      r_err        <= w_err_nxt;
      r_resp_valid <= (w_state_nxt == ST_RESP);
    end
  end

  // Next-state, grant and ROM address
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_id_nxt     = r_id;
    w_piece_nxt  = r_piece;
    w_ptr_nxt    = r_ptr;
    w_shape_nxt  = r_shape;
    w_err_nxt    = r_err;
    req_ready    = '0;
    rom_addr     = '0;

    case (r_state)
      ST_IDLE: begin
        req_ready = w_grant;
        if (w_accept) begin
          w_id_nxt     = w_sel;
          w_piece_nxt  = req_piece[w_sel];
          w_rr_ptr_nxt = ~w_sel;
          w_shape_nxt  = '0;
          // Invalid codes answer immediately with an error and no ROM access
          if (piece_valid(req_piece[w_sel])) begin
            w_err_nxt   = 1'b0;
            w_state_nxt = ST_IDX;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_IDX: begin
        rom_addr    = ADDR_W'(r_piece);
        w_state_nxt = ST_PTR;
      end
      ST_PTR: begin
        // Pointer byte arrives now; use it directly as the first row address
        rom_addr    = rom_data[ADDR_W-1:0];
        w_ptr_nxt   = rom_data[ADDR_W-1:0];
        w_state_nxt = ST_ROW01;
      end
      ST_ROW01: begin
        w_shape_nxt[15:8] = 8'(rom_data);
        rom_addr          = r_ptr + ADDR_W'(1);
        w_state_nxt       = ST_ROW23;
      end
      ST_ROW23: begin
        w_shape_nxt[7:0] = 8'(rom_data);
        w_state_nxt      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_id;
  assign resp_piece = r_piece;
  assign resp_shape = r_shape;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_piece_rom_arbiter.sv
// Directed bench for piece_rom_arbiter with a synchronous-read ROM model.
module tb_piece_rom_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0][3:0]  req_piece;
  logic [1:0]       req_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [3:0]       resp_piece;
  logic [15:0]      resp_shape;
  logic             resp_err;
  logic [6:0]       rom_addr;
  logic [7:0]       rom_data;

  logic [7:0]       mem [0:127];

  int checks = 0;
  int errors = 0;

  piece_rom_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_piece  (req_piece),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_piece (resp_piece),
    .resp_shape (resp_shape),
    .resp_err   (resp_err),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept in the current IDLE cycle, then expect resp_valid exactly lat cycles later
  task automatic txn(input logic [1:0] exp_grant, input logic exp_id, input logic [3:0] exp_piece,
                     input logic [15:0] exp_shape, input logic exp_err, input int lat, input bit drop);
    #1;
    chk("grant", 32'(req_ready), 32'(exp_grant));
    tick();
    if (drop) req_valid = 2'b00;
    for (int i = 1; i < lat; i++) begin
      chk("busy_ready", 32'(req_ready), 32'd0);
      chk("early_valid", 32'(resp_valid), 32'd0);
      tick();
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_id", 32'(resp_id), 32'(exp_id));
    chk("resp_piece", 32'(resp_piece), 32'(exp_piece));
    chk("resp_shape", 32'(resp_shape), 32'(exp_shape));
    chk("resp_err", 32'(resp_err), 32'(exp_err));
  endtask

  initial begin
    for (int a = 0; a < 128; a++) mem[a] = 8'h00;
    mem[2]    = 8'h20; mem[8'h20] = 8'h66; mem[8'h21] = 8'h00;
    mem[1]    = 8'h30; mem[8'h30] = 8'h0E; mem[8'h31] = 8'h40;
    mem[7]    = 8'h40; mem[8'h40] = 8'h44; mem[8'h41] = 8'h44;
    mem[3]    = 8'h7F; mem[8'h7F] = 8'hA5; mem[8'h00] = 8'h3C;

    rst = 1'b1; req_valid = 2'b00; req_piece = '0; resp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_shape", 32'(resp_shape), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_piece", 32'(resp_piece), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single lookup, piece 2 from requester 0
    req_valid = 2'b01; req_piece[0] = 4'd2;
    txn(2'b01, 1'b0, 4'd2, 16'h6600, 1'b0, 5, 1'b1);
    tick();
    chk("t1_drop", 32'(resp_valid), 32'd0);

    // Fairness: both held valid, fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 2'b11; req_piece[0] = 4'd1; req_piece[1] = 4'd7;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) txn(2'b01, 1'b0, 4'd1, 16'h0E40, 1'b0, 5, 1'b0);
      else            txn(2'b10, 1'b1, 4'd7, 16'h4444, 1'b0, 5, 1'b0);
      if (k == 3) req_valid = 2'b00;
      tick();
    end

    // Invalid codes 9 then 0 from requester 1
    req_valid = 2'b10; req_piece[1] = 4'd9;
    #1;
    chk("inv_addr0", 32'(rom_addr), 32'd0);
    txn(2'b10, 1'b1, 4'd9, 16'h0000, 1'b1, 1, 1'b0);
    chk("inv_addr1", 32'(rom_addr), 32'd0);
    req_piece[1] = 4'd0;
    tick();
    chk("inv_addr2", 32'(rom_addr), 32'd0);
    txn(2'b10, 1'b1, 4'd0, 16'h0000, 1'b1, 1, 1'b1);
    chk("inv_addr3", 32'(rom_addr), 32'd0);
    tick();

    // Pointer wrap 0x7F -> 0x00
    req_valid = 2'b01; req_piece[0] = 4'd3;
    #1;
    chk("wrap_grant", 32'(req_ready), 32'd1);
    tick(); req_valid = 2'b00;
    chk("wrap_a0", 32'(rom_addr), 32'h03);
    tick();
    chk("wrap_a1", 32'(rom_addr), 32'h7F);
    tick();
    chk("wrap_a2", 32'(rom_addr), 32'h00);
    tick(); tick();
    chk("wrap_valid", 32'(resp_valid), 32'd1);
    chk("wrap_shape", 32'(resp_shape), 32'hA53C);
    chk("wrap_piece", 32'(resp_piece), 32'd3);
    tick();

    // Backpressure: pointer now favours requester 1
    resp_ready = 1'b0;
    req_valid = 2'b11; req_piece[0] = 4'd2; req_piece[1] = 4'd7;
    txn(2'b10, 1'b1, 4'd7, 16'h4444, 1'b0, 5, 1'b0);
    req_valid = 2'b01;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_shape", 32'(resp_shape), 32'h4444);
      chk("bp_id", 32'(resp_id), 32'd1);
      chk("bp_piece", 32'(resp_piece), 32'd7);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    txn(2'b01, 1'b0, 4'd2, 16'h6600, 1'b0, 5, 1'b1);
    tick();

    // Reset in ROW01 abandons the lookup and clears the pointer
    req_valid = 2'b01; req_piece[0] = 4'd1;
    #1;
    chk("r1_grant", 32'(req_ready), 32'd1);
    tick(); req_valid = 2'b00;
    tick(); tick();
    chk("r1_row01", 32'(rom_addr), 32'h31);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11; req_piece[1] = 4'd7;
    chk("r1_valid", 32'(resp_valid), 32'd0);
    txn(2'b01, 1'b0, 4'd1, 16'h0E40, 1'b0, 5, 1'b1);
    tick();

    // Reset while stalled in RESP
    resp_ready = 1'b0;
    req_valid = 2'b01; req_piece[0] = 4'd2;
    txn(2'b01, 1'b0, 4'd2, 16'h6600, 1'b0, 5, 1'b1);
    tick();
    chk("r2_hold", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11; req_piece[0] = 4'd2; req_piece[1] = 4'd7;
    #1;
    chk("r2_valid", 32'(resp_valid), 32'd0);
    chk("r2_shape", 32'(resp_shape), 32'd0);
    chk("r2_piece", 32'(resp_piece), 32'd0);
    resp_ready = 1'b1;
    txn(2'b01, 1'b0, 4'd2, 16'h6600, 1'b0, 5, 1'b1);
    tick();
    chk("r2_done", 32'(resp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
